// File: rtl/aes_matrix_gen_ctrl_if.sv
`default_nettype none
// ============================================================================
// aes_matrix_gen_ctrl_if : AES core bus plus output block stream
// Rev 1.0
// ============================================================================
interface aes_matrix_gen_ctrl_if;
  logic [127:0] aes_key;
  logic         aes_start_key_schedule;
  logic         aes_done_key_schedule;
  logic [127:0] aes_data;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_rdata;
  logic [127:0] blk_data;
  logic [15:0]  blk_row;
  logic [15:0]  blk_col;
  logic         blk_valid;
  logic         blk_ready;

  modport master (
    output aes_key, aes_start_key_schedule, aes_data, aes_start,
    output blk_data, blk_row, blk_col, blk_valid,
    input  aes_done_key_schedule, aes_done, aes_rdata, blk_ready
  );

  modport slave (
    input  aes_key, aes_start_key_schedule, aes_data, aes_start,
    input  blk_data, blk_row, blk_col, blk_valid,
    output aes_done_key_schedule, aes_done, aes_rdata, blk_ready
  );
endinterface
`default_nettype wire

// File: rtl/aes_matrix_gen_ctrl.sv
`default_nettype none
// ============================================================================
// aes_matrix_gen_ctrl : FrodoKEM matrix-A AES sequencer (optional AESGEN_KEY_CACHE_EN)
// Rev 1.0
// ============================================================================
module aes_matrix_gen_ctrl #(
  parameter int N_DIM        = 640,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [127:0]          i_seed_key,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  aes_matrix_gen_ctrl_if.master bus
);
  localparam int              CNT_W      = $clog2(MAX_INFLIGHT + 1);
  localparam int              PTR_W      = $clog2(MAX_INFLIGHT);
  localparam logic [15:0]     LAST_ROW   = 16'(N_DIM - 1);
  localparam logic [15:0]     LAST_COL   = 16'(N_DIM - 8);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KEY_START = 3'd1,
    S_KEY_WAIT  = 3'd2,
    S_ISSUE     = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [15:0]      iss_row_q, iss_row_d, iss_col_q, iss_col_d;
  logic [15:0]      out_row_q, out_row_d, out_col_q, out_col_d;
  logic [CNT_W-1:0] credit_q, credit_d, fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [127:0]     fifo_mem_q [MAX_INFLIGHT];
  logic             issue, pop, push, start_ks, done_pulse;
`ifdef AESGEN_KEY_CACHE_EN
  logic             cache_valid_q, cache_valid_d;
`endif

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    iss_row_d  = iss_row_q;
    iss_col_d  = iss_col_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    start_ks   = 1'b0;
    issue      = 1'b0;
    done_pulse = 1'b0;
`ifdef AESGEN_KEY_CACHE_EN
    cache_valid_d = cache_valid_q;
`endif
    pop  = (fifo_cnt_q != '0) && bus.blk_ready;
    // Results arriving outside an active run are dropped, not buffered.
    push = bus.aes_done && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

    if (pop) begin
      if (out_col_q == LAST_COL) begin
        out_col_d = '0;
        out_row_d = out_row_q + 16'd1;
      end else begin
        out_col_d = out_col_q + 16'd8;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          iss_row_d = '0;
          iss_col_d = '0;
          out_row_d = '0;
          out_col_d = '0;
          key_d     = i_seed_key;
`ifdef AESGEN_KEY_CACHE_EN
          if (cache_valid_q && (i_seed_key == key_q)) state_d = S_ISSUE;
          else                                        state_d = S_KEY_START;
`else
          state_d = S_KEY_START;
`endif
        end
      end
      S_KEY_START: begin
        start_ks = 1'b1;
        state_d  = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        if (bus.aes_done_key_schedule) begin
          state_d = S_ISSUE;
`ifdef AESGEN_KEY_CACHE_EN
          cache_valid_d = 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        if (credit_q < CREDIT_MAX) begin
          issue = 1'b1;
          if (iss_col_q == LAST_COL) begin
            iss_col_d = '0;
            iss_row_d = iss_row_q + 16'd1;
            if (iss_row_q == LAST_ROW) state_d = S_DRAIN;
          end else begin
            iss_col_d = iss_col_q + 16'd8;
          end
        end
      end
      S_DRAIN: begin
        if (pop && (out_row_q == LAST_ROW) && (out_col_q == LAST_COL)) state_d = S_DONE;
      end
      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    credit_d = credit_q;
    if (issue && !pop)      credit_d = credit_q + CNT_W'(1);
    else if (!issue && pop) credit_d = credit_q - CNT_W'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      iss_row_q  <= '0;
      iss_col_q  <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      credit_q   <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef AESGEN_KEY_CACHE_EN
      cache_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      iss_row_q  <= iss_row_d;
      iss_col_q  <= iss_col_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      credit_q   <= credit_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef AESGEN_KEY_CACHE_EN
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.aes_rdata;
  end

  assign bus.aes_key                = key_q;
  assign bus.aes_start_key_schedule = start_ks;
  assign bus.aes_start              = issue;
  assign bus.aes_data               = {iss_row_q[7:0], iss_row_q[15:8],
                                       iss_col_q[7:0], iss_col_q[15:8], 96'h0};
  assign bus.blk_valid              = (fifo_cnt_q != '0);
  // Head word is masked so the output bus reads zero while the FIFO is empty.
  assign bus.blk_data               = (fifo_cnt_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
  assign bus.blk_row                = out_row_q;
  assign bus.blk_col                = out_col_q;
  assign o_busy                     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done                     = done_pulse;
endmodule
`default_nettype wire

// File: tb/tb_aes_matrix_gen_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes_matrix_gen_ctrl : directed bench with a pipelined mock AES core
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes_matrix_gen_ctrl;
  localparam int N    = 16;
  localparam int MAXF = 4;
  localparam int NBLK = N * N / 8;
  localparam logic [127:0] K1 = 128'h129cd242996d818ca55c2abbff0ddc61;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0, spur = 1'b0;
  logic [127:0] seed = '0;
  logic         busy, done;

  always #5 clk = ~clk;

  aes_matrix_gen_ctrl_if bus_if();

  aes_matrix_gen_ctrl #(.N_DIM(N), .MAX_INFLIGHT(MAXF)) dut (
    .i_clk(clk), .i_rst(rst), .i_seed_key(seed), .i_start(start),
    .o_busy(busy), .o_done(done), .bus(bus_if)
  );

  // Stand-in cipher: any fixed keyed permutation suffices to track data ordering.
  function automatic logic [127:0] mock_enc(input logic [127:0] pt, input logic [127:0] k);
    return {pt[63:0], pt[127:64]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] pt_of(input logic [15:0] r, input logic [15:0] c);
    logic [127:0] p;
    p = '0;
    p[127:120] = r[7:0];
    p[119:112] = r[15:8];
    p[111:104] = c[7:0];
    p[103:96]  = c[15:8];
    return p;
  endfunction

  // Mock core: 3-cycle pipeline, key schedule completes 4 cycles after its start pulse.
  logic [2:0]   pv;
  logic [127:0] pd [3];
  logic [2:0]   ks_t;
  always @(posedge clk) begin
    if (rst) begin
      pv   <= '0;
      ks_t <= '0;
    end else begin
      pv   <= {pv[1:0], bus_if.aes_start};
      ks_t <= bus_if.aes_start_key_schedule ? 3'd4 : ((ks_t != 3'd0) ? ks_t - 3'd1 : 3'd0);
    end
    pd[2] <= pd[1];
    pd[1] <= pd[0];
    pd[0] <= mock_enc(bus_if.aes_data, bus_if.aes_key);
  end
  assign bus_if.aes_done              = pv[2] | spur;
  assign bus_if.aes_rdata             = pd[2];
  assign bus_if.aes_done_key_schedule = (ks_t == 3'd1);
  assign bus_if.blk_ready             = ready;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, iss_cnt, pop_cnt, done_cnt, ks_cnt, credit, max_credit;
  int start_cyc, ks_cyc, ksdone_cyc, first_iss_cyc;
  logic [127:0] first_pt [3];
  logic [127:0] run_key;
  logic [15:0]  exp_row, exp_col, last_row, last_col;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (start && !busy) start_cyc = cyc;
      if (bus_if.aes_start_key_schedule) begin ks_cnt++; ks_cyc = cyc; end
      if (bus_if.aes_done_key_schedule) ksdone_cyc = cyc;
      if (bus_if.aes_start) begin
        if (iss_cnt < 3) first_pt[iss_cnt] = bus_if.aes_data;
        if (iss_cnt == 0) first_iss_cyc = cyc;
        iss_cnt++;
        credit++;
      end
      if (bus_if.blk_valid && ready) begin
        check("blk_row", bus_if.blk_row, exp_row);
        check("blk_col", bus_if.blk_col, exp_col);
        check("blk_data", bus_if.blk_data, mock_enc(pt_of(exp_row, exp_col), run_key));
        last_row = exp_row;
        last_col = exp_col;
        if (exp_col == 16'(N - 8)) begin exp_col = '0; exp_row = exp_row + 16'd1; end
        else exp_col = exp_col + 16'd8;
        pop_cnt++;
        credit--;
      end
      if (credit > max_credit) max_credit = credit;
      if (done) done_cnt++;
    end
  end

  task automatic clear_stats();
    iss_cnt = 0; pop_cnt = 0; done_cnt = 0; ks_cnt = 0; credit = 0; max_credit = 0;
    start_cyc = 0; ks_cyc = -100; ksdone_cyc = -100; first_iss_cyc = -100;
    exp_row = '0; exp_col = '0; last_row = '0; last_col = '0;
    for (int i = 0; i < 3; i++) first_pt[i] = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    seed = k; run_key = k; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("done_within_budget", done_cnt != 0, 1);
  endtask

  task automatic check_first_three(input string tag);
    check({tag, "_pt0"}, first_pt[0], 128'h0);
    check({tag, "_pt1"}, first_pt[1], 128'h00000800_00000000_00000000_00000000);
    check({tag, "_pt2"}, first_pt[2], 128'h01000000_00000000_00000000_00000000);
  endtask

  initial begin
    clear_stats();
    run_key = K1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus_if.blk_valid, 0);
    check("rst_aes_start", bus_if.aes_start, 0);
    check("rst_ks", bus_if.aes_start_key_schedule, 0);
    check("rst_key", bus_if.aes_key, 0);
    check("rst_blk_data", bus_if.blk_data, 0);
    check("rst_blk_row", bus_if.blk_row, 0);
    rst = 1'b0;
    tick();

    spur = 1'b1; tick(); spur = 1'b0; tick();
    check("spurious_done_ignored", bus_if.blk_valid, 0);

    // Baseline run, with a start pulse injected while busy.
    ready = 1'b1;
    do_start(K1);
    check("ks_pulse", bus_if.aes_start_key_schedule, 1);
    check("busy_rise", busy, 1);
    tick();
    check("ks_one_cycle", bus_if.aes_start_key_schedule, 0);
    repeat (10) tick();
    seed = K2; start = 1'b1; tick(); start = 1'b0;
    wait_done(600, 1'b0);
    repeat (3) tick();
    check_first_three("s1");
    check("s1_pops", pop_cnt, NBLK);
    check("s1_issues", iss_cnt, NBLK);
    check("s1_done_once", done_cnt, 1);
    check("s1_last_row", last_row, N - 1);
    check("s1_last_col", last_col, N - 8);
    check("s1_ks_latency", ks_cyc - start_cyc, 1);
    check("s1_issue_latency", first_iss_cyc - ksdone_cyc, 1);
    check("s1_key_held", bus_if.aes_key, K1);
    check("s1_idle", busy, 0);

    // Output stalled: issue must stop at MAX_INFLIGHT.
    clear_stats();
    ready = 1'b0;
    do_start(K1);
    repeat (40) tick();
    check("stall_issue_count", iss_cnt, MAXF);
    check("stall_valid", bus_if.blk_valid, 1);
    check("stall_busy", busy, 1);
    ready = 1'b1;
    wait_done(600, 1'b0);
    repeat (3) tick();
    check("stall_pops", pop_cnt, NBLK);
    check("stall_issues", iss_cnt, NBLK);
    check("stall_done_once", done_cnt, 1);

    // Random backpressure.
    clear_stats();
    ready = 1'b0;
    do_start(K2);
    wait_done(3000, 1'b1);
    ready = 1'b1;
    repeat (3) tick();
    check("rnd_pops", pop_cnt, NBLK);
    check("rnd_credit_bound", max_credit <= MAXF, 1);
    check("rnd_last_row", last_row, N - 1);
    check("rnd_last_col", last_col, N - 8);

    // Reset during DRAIN, then a clean rerun.
    clear_stats();
    ready = 1'b1;
    do_start(K1);
    for (int i = 0; i < 600 && iss_cnt < NBLK; i++) tick();
    check("abort_reached_drain", iss_cnt, NBLK);
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", bus_if.blk_valid, 0);
    rst = 1'b0;
    repeat (10) tick();
    check("abort_no_done", done_cnt, 0);
    clear_stats();
    do_start(K1);
    wait_done(600, 1'b0);
    repeat (3) tick();
    check_first_three("rerun");
    check("rerun_pops", pop_cnt, NBLK);
    check("rerun_done_once", done_cnt, 1);
    check("rerun_ks_count", ks_cnt, 1);

`ifdef AESGEN_KEY_CACHE_EN
    clear_stats();
    do_start(K1);
    wait_done(600, 1'b0);
    repeat (3) tick();
    check("cache_hit_no_ks", ks_cnt, 0);
    check("cache_hit_latency", first_iss_cyc - start_cyc, 1);
    check("cache_hit_pops", pop_cnt, NBLK);
    clear_stats();
    do_start(K3);
    wait_done(600, 1'b0);
    repeat (3) tick();
    check("cache_miss_ks", ks_cnt, 1);
    check("cache_miss_pops", pop_cnt, NBLK);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/aes_matrix_gen_ctrl.md
Name: aes_matrix_gen_ctrl

Overview:
Sequencer for the aes128 core that generates FrodoKEM matrix A in AES mode.
- Starts the core's key schedule with the seed key, then issues one plaintext block per (row, col) position, with col stepping by 8.
- Keeps several blocks in flight in the core's pipeline, buffers the results, and streams them out with valid/ready.
- Sits between the matrix-multiply datapath, which consumes the 128-bit blocks (eight 16-bit elements each), and the shared aes128 instance.

Parameters:
N_DIM, 640, matrix dimension n. Must be a multiple of 8 and ≤ 65535. Blocks per row = N_DIM/8.
MAX_INFLIGHT, 4, maximum of (blocks issued but not yet returned) + (blocks held in the output FIFO). Equals the FIFO depth. Power of 2, ≥ 2.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high; shared with the aes128 core
i_seed_key  in  128  AES key (seedA expansion); sampled on i_start
i_start  in  1  1-cycle start pulse; ignored while o_busy=1
o_busy  out  1  high from the accepted i_start until o_done
o_done  out  1  1-cycle pulse after the last block is popped
o_aes_key  out  128  key to the core; registered copy of i_seed_key
o_aes_start_key_schedule  out  1  1-cycle pulse
i_aes_done_key_schedule  in  1  key-schedule-complete pulse from the core
o_aes_data  out  128  plaintext block to the core
o_aes_start  out  1  1 = o_aes_data is valid this cycle; the core accepts one block per cycle
i_aes_done  in  1  1 = i_aes_data holds a result; results return in issue order
i_aes_data  in  128  ciphertext from the core
o_blk_data  out  128  output block
o_blk_row  out  16  row index of o_blk_data
o_blk_col  out  16  column index of the first element of o_blk_data
o_blk_valid  out  1  output valid
i_blk_ready  in  1  output ready; a transfer occurs when valid && ready

Behaviour:
- Reset values: every output 0, FSM in IDLE, FIFO empty, all counters 0. Reset mid-operation aborts immediately; no o_done is produced.
- Plaintext format (byte0 = bits[127:120]):
  - byte0 = row[7:0], byte1 = row[15:8]
  - byte2 = col[7:0], byte3 = col[15:8]
  - bytes 4..15 = 0
- Issue order: row 0..N_DIM-1 (outer loop), col 0, 8, …, N_DIM-8 (inner loop).
- FSM:
  - IDLE: on i_start, latch the key into o_aes_key → KEY_START.
  - KEY_START: o_aes_start_key_schedule=1 for exactly one cycle → KEY_WAIT.
  - KEY_WAIT: on i_aes_done_key_schedule → ISSUE. No blocks are issued before this.
  - ISSUE: o_aes_start=1 in any cycle where credit < MAX_INFLIGHT. When the last block issues → DRAIN.
  - DRAIN: when the last block is popped (all N_DIM²/8 blocks) → DONE.
  - DONE: o_done=1 for one cycle, o_busy falls in the same cycle → IDLE.
- Credit counter:
  - credit = in-flight + FIFO occupancy.
  - +1 on each issue; −1 on each output pop.
  - Issue and pop in the same cycle: credit unchanged.
- A back-to-back issue rate of 1 block/cycle is required whenever credit permits.
- FIFO:
  - Pushed on every i_aes_done; the credit rule makes overflow impossible.
  - First-word fall-through: o_blk_valid = !empty.
  - Simultaneous push and pop while full-minus-0 is legal.
  - Pop of an empty FIFO cannot occur.
- Output indices: a separate out_row/out_col counter advances on each pop, in issue order. o_blk_row and o_blk_col reflect the FIFO head.
- Stall: i_blk_ready=0 freezes output and stops issuing once credit=MAX_INFLIGHT. No data is lost or duplicated.
- Wrap-around:
  - col wraps from N_DIM-8 to 0, and row increments at the same time.
  - The last block is row=N_DIM-1, col=N_DIM-8.
- Spurious i_aes_done while not in ISSUE/DRAIN is ignored (not pushed).
- Latency:
  - i_start → o_aes_start_key_schedule: 1 cycle.
  - i_aes_done_key_schedule → first o_aes_start: 1 cycle.

Optional Feature:
AESGEN_KEY_CACHE_EN
- Defined:
  - Adds a cache_valid flag, cleared by reset.
  - On i_start, if cache_valid=1 and i_seed_key equals o_aes_key, the FSM goes IDLE → ISSUE directly and skips the key schedule.
  - Otherwise the normal path runs, and cache_valid is set on i_aes_done_key_schedule.
- Undefined: every i_start runs KEY_START/KEY_WAIT.

Test Plan:
- N_DIM=16, key 128'h129cd242996d818ca55c2abbff0ddc61, i_blk_ready=1 → the first three o_aes_data values are:
  - 128'h0
  - 128'h00000800_00000000_00000000_00000000
  - 128'h01000000_00000000_00000000_00000000

  Also required: 32 blocks popped, o_done pulses once, and every o_blk_data matches a reference AES model.
- Hold i_blk_ready=0 after start, MAX_INFLIGHT=4 → exactly 4 o_aes_start pulses, then issue stops. Release ready → the remaining 28 blocks arrive in order with correct row/col.
- Random i_blk_ready (50%) with N_DIM=64 → 512 blocks, no drops or duplicates, credit never exceeds 4, last block is row=63, col=56.
- Assert i_rst mid-DRAIN, then re-start → o_busy=0 and o_blk_valid=0 in the cycle after reset; the rerun matches scenario 1 exactly.
- i_start pulse while busy → ignored; block count stays 32.
- With AESGEN_KEY_CACHE_EN defined, two runs with the same key → no o_aes_start_key_schedule pulse on the second run, and first o_aes_start comes 1 cycle after i_start. A changed key → the key schedule runs again.
